// File: rtl/neopixel_pkg.sv
// Shared types and helpers for the WS2812-class multi-string serialiser.
// Latency: n/a (types, constants and an elaboration-time function only).
// Backpressure: n/a.
package neopixel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        BIT,
        LATCH,
        DONE
    } state_t;

    // Byte order on the wire: G, R, B (and W for the 4-byte variant).
    localparam int BYTES_GRB  = 3;
    localparam int BYTES_GRBW = 4;

    // Clock ticks in a duration of ns nanoseconds, truncated, never below 1.
    // 64-bit math: 50 kHz-per-ns products overflow 32 bits for the latch time.
    function automatic int ticks(input longint clk_hz, input longint ns);
        longint t;
        t = (clk_hz / 1000) * ns / 1_000_000;
        return (t < 1) ? 1 : int'(t);
    endfunction

endpackage

// File: rtl/neopixel_lane.sv
// One LED string: 8-bit MSB-first shift register, optional brightness scaler, high-time compare.
// Latency: line is registered; it reflects the bit/tick the driver moves into on the same edge.
// Backpressure: none; load/shift/tick are dictated by the driver's fixed bit timing.
// Ports: clk/rst (sync, active high), load/shift strobes, active_nxt + tick_nxt (next bit-slot
// state), data (frame-RAM byte lane), brightness (only with NEOPIXEL_BRIGHTNESS_EN), line (pad).
module neopixel_lane
    import neopixel_pkg::*;
#(
    parameter int CW  = 12,
    parameter int T0H = 17,
    parameter int T1H = 35
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          shift,
    input  logic          active_nxt,
    input  logic [CW-1:0] tick_nxt,
`ifdef NEOPIXEL_BRIGHTNESS_EN
    input  logic [7:0]    brightness,
`endif
    input  logic [7:0]    data,
    output logic          line
);

    logic [7:0] load_byte;
    logic [7:0] sr;
    logic [7:0] sr_nxt;

`ifdef NEOPIXEL_BRIGHTNESS_EN
    // (data * (brightness + 1)) >> 8, so brightness 255 passes data through unchanged.
    logic [16:0] prod;
    assign prod      = {9'd0, data} * ({9'd0, brightness} + 17'd1);
    assign load_byte = 8'(prod >> 8);
`else
    assign load_byte = data;
`endif

    always_comb begin
        sr_nxt = sr;
        if (load) begin
            sr_nxt = load_byte;
        end else if (shift) begin
            sr_nxt = {sr[6:0], 1'b0};
        end
    end

    // Output is computed from the next-cycle shift register and tick so the pad
    // rises on the very first cycle of every bit slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr   <= '0;
            line <= 1'b0;
        end else begin
            sr   <= sr_nxt;
            line <= active_nxt && (tick_nxt < (sr_nxt[7] ? CW'(T1H) : CW'(T0H)));
        end
    end

endmodule

// File: rtl/neopixel_multi_driver.sv
// WS2812-class serialiser driving CHANNELS strings in lock-step from one shared frame-RAM read port.
// Latency: first pad rise 2 cycles after i_start; frame = bytes*8*TBIT + TRST cycles + 1 DONE cycle.
// Backpressure: none; i_start is ignored while o_busy=1 (including the o_frame_done cycle).
// Ports: i_clk, i_rst (sync, active high), i_start, o_busy, o_rd_addr (byte address, 1-cycle RAM),
// i_data (lane c = [8c+7:8c]), o_neopixel_out (one per string), o_frame_done (1-cycle pulse).
// Option: NEOPIXEL_BRIGHTNESS_EN adds i_brightness, captured at start and applied to every byte.
module neopixel_multi_driver
    import neopixel_pkg::*;
#(
    parameter int LEDS          = 200,
    parameter int CHANNELS      = 4,
    parameter int BYTES_PER_LED = 3,
    parameter int CLK_HZ        = 50_000_000,
    parameter int T0H_NS        = 350,
    parameter int T1H_NS        = 700,
    parameter int TBIT_NS       = 1300,
    parameter int TRST_NS       = 50_000
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic                                      i_start,
    output logic                                      o_busy,
    output logic [$clog2(LEDS*BYTES_PER_LED)-1:0]     o_rd_addr,
    input  logic [CHANNELS*8-1:0]                     i_data,
`ifdef NEOPIXEL_BRIGHTNESS_EN
    input  logic [7:0]                                i_brightness,
`endif
    output logic [CHANNELS-1:0]                       o_neopixel_out,
    output logic                                      o_frame_done
);

    localparam int NBYTES = LEDS * BYTES_PER_LED;
    localparam int AW     = $clog2(NBYTES);
    localparam int T0H_T  = ticks(CLK_HZ, T0H_NS);
    localparam int T1H_T  = ticks(CLK_HZ, T1H_NS);
    localparam int TBIT_T = ticks(CLK_HZ, TBIT_NS);
    localparam int TRST_T = ticks(CLK_HZ, TRST_NS);
    // One counter serves both the bit slot and the latch period.
    localparam int CW     = $clog2(((TRST_T > TBIT_T) ? TRST_T : TBIT_T) + 1);

    if (BYTES_PER_LED != BYTES_GRB && BYTES_PER_LED != BYTES_GRBW) begin : g_bad_bpl
        $error("neopixel_multi_driver: BYTES_PER_LED must be 3 (GRB) or 4 (GRBW)");
    end
    if (!(T1H_T < TBIT_T) || !(T0H_T < T1H_T)) begin : g_bad_timing
        $error("neopixel_multi_driver: need T0H < T1H < TBIT in clock ticks");
    end

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] tick;
    logic [CW-1:0] tick_nxt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_nxt;
    logic [AW-1:0] byte_cnt;
    logic [AW-1:0] byte_nxt;
    logic [AW-1:0] addr_nxt;
    logic          busy_nxt;
    logic          load;
    logic          shift;
    logic          last_byte;
    logic          active_nxt;

    assign last_byte    = (byte_cnt == AW'(NBYTES - 1));
    assign active_nxt   = (state_nxt == BIT);
    assign o_frame_done = (state == DONE);

`ifdef NEOPIXEL_BRIGHTNESS_EN
    logic [7:0] bright_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bright_q <= '0;
        end else if (state == IDLE && i_start) begin
            bright_q <= i_brightness;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick;
        bit_nxt   = bit_cnt;
        byte_nxt  = byte_cnt;
        addr_nxt  = o_rd_addr;
        busy_nxt  = o_busy;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = FETCH;
                    busy_nxt  = 1'b1;
                    addr_nxt  = '0;
                    byte_nxt  = '0;
                    tick_nxt  = '0;
                end
            end
            FETCH: begin
                // Address 0 was presented last cycle, so i_data now holds byte 0.
                load      = 1'b1;
                bit_nxt   = '0;
                tick_nxt  = '0;
                state_nxt = BIT;
            end
            BIT: begin
                tick_nxt = tick + 1'b1;
                // Advance the address early enough that the next byte is on i_data
                // at the final tick of bit 7, giving a gap-free byte boundary.
                if (bit_cnt == 3'd7 && tick == CW'(TBIT_T - 3) && !last_byte) begin
                    addr_nxt = o_rd_addr + 1'b1;
                end
                if (tick == CW'(TBIT_T - 1)) begin
                    tick_nxt = '0;
                    if (bit_cnt != 3'd7) begin
                        shift   = 1'b1;
                        bit_nxt = bit_cnt + 3'd1;
                    end else if (!last_byte) begin
                        load     = 1'b1;
                        bit_nxt  = '0;
                        byte_nxt = byte_cnt + 1'b1;
                    end else begin
                        state_nxt = LATCH;
                    end
                end
            end
            LATCH: begin
                tick_nxt = tick + 1'b1;
                if (tick == CW'(TRST_T - 1)) begin
                    tick_nxt  = '0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                addr_nxt  = '0;
                tick_nxt  = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            tick      <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            o_rd_addr <= '0;
            o_busy    <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick      <= tick_nxt;
            bit_cnt   <= bit_nxt;
            byte_cnt  <= byte_nxt;
            o_rd_addr <= addr_nxt;
            o_busy    <= busy_nxt;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        neopixel_lane #(
            .CW  (CW),
            .T0H (T0H_T),
            .T1H (T1H_T)
        ) u_lane (
            .clk        (i_clk),
            .rst        (i_rst),
            .load       (load),
            .shift      (shift),
            .active_nxt (active_nxt),
            .tick_nxt   (tick_nxt),
`ifdef NEOPIXEL_BRIGHTNESS_EN
            .brightness (bright_q),
`endif
            .data       (i_data[8*c +: 8]),
            .line       (o_neopixel_out[c])
        );
    end

endmodule

// File: doc/neopixel_multi_driver.md
Name: neopixel_multi_driver

Overview:
- Next-generation WS2812-class serialiser. Drives CHANNELS LED strings in lock-step from one shared frame-buffer read port.
- Supports RGB or RGBW pixels (BYTES_PER_LED) and a programmable bit and latch timing.
- Sits between the SPI-written frame RAM (1-cycle synchronous read) and the pads. One i_start pulse per frame.

Parameters:
- LEDS, 200: pixels per channel.
- CHANNELS, 4: parallel strings; each has its own byte lane of i_data.
- BYTES_PER_LED, 3: 3 = GRB, 4 = GRBW. Other values are illegal; elaboration-time $error.
- CLK_HZ, 50_000_000: clock frequency.
- T0H_NS / T1H_NS / TBIT_NS / TRST_NS, 350 / 700 / 1300 / 50_000: high time for a 0 bit, high time for a 1 bit, bit period, latch low time.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  frame request pulse; ignored while o_busy=1
- o_busy  out  1  high from start acceptance until o_frame_done
- o_rd_addr  out  $clog2(LEDS*BYTES_PER_LED)  byte address, common to all channels
- i_data  in  CHANNELS*8  read data, valid 1 cycle after o_rd_addr; lane c = [8c+7:8c]
- o_neopixel_out  out  CHANNELS  serial data per string
- o_frame_done  out  1  single-cycle pulse at end of latch period

Behaviour:
- Tick counts: ticks(ns) = max(1, CLK_HZ/1000 * ns / 1_000_000), truncating. At 50 MHz this gives T0H=17, T1H=35, TBIT=65, TRST=2500.
- Elaboration checks: T1H < TBIT and T0H < T1H; otherwise $error.
- Reset (and reset mid-frame): state=IDLE, o_busy=0, o_rd_addr=0, o_neopixel_out=0, o_frame_done=0, all counters=0. Takes effect on the next edge; no partial bit is completed.
- States: IDLE, FETCH, BIT, LATCH, DONE.
- IDLE:
  - On i_start=1: o_busy←1, o_rd_addr←0, go to FETCH.
- FETCH (exactly 1 cycle, waits for read latency):
  - Capture i_data into the per-channel shift registers, MSB first.
  - Bit counter←0, tick counter←0, go to BIT.
  - The first high edge on o_neopixel_out is 2 cycles after the i_start cycle.
- BIT:
  - Tick counter counts 0..TBIT-1.
  - o_neopixel_out[c] = (tick < (sr[c][7] ? T1H : T0H)), registered. All lanes rise together; each falls at its own T0H/T1H point.
  - Prefetch: at tick==TBIT-3 of bit 7, o_rd_addr←o_rd_addr+1, unless the current byte is the last one.
  - At tick==TBIT-1:
    - Bits 0..6: shift left.
    - Bit 7, not last byte: load the shift registers from i_data.
    - Bit 7, last byte: go to LATCH.
  - No idle cycles between bits or bytes. Frame length in BIT = LEDS*BYTES_PER_LED*8*TBIT cycles exactly.
- LATCH:
  - o_neopixel_out=0 for TRST cycles, then go to DONE.
- DONE (1 cycle):
  - o_frame_done=1, o_busy←0, o_rd_addr←0, go to IDLE.
  - An i_start asserted in this same cycle is ignored. A new start is accepted the following cycle.
- Address never wraps or exceeds LEDS*BYTES_PER_LED-1.
- Frame-RAM writes during a frame are the SPI side's responsibility. The driver samples each byte only at its load point.

Optional Feature:
- Macro: NEOPIXEL_BRIGHTNESS_EN.
- Enabled:
  - Extra port i_brightness, in, 8 bits, sampled once when i_start is accepted and held for the whole frame.
  - Each loaded byte becomes (data*(brightness+1))>>8. This scaling is combinational, between i_data and the shift-register load. brightness=255 is identity.
- Disabled:
  - Port absent; bytes are loaded unmodified.
- Timing and cycle counts are identical in both builds.

Decomposition:
- neopixel_pkg:
  - state_t enum.
  - ticks() constant function.
  - GRB/GRBW byte-order localparams.
- One natural sub-module: neopixel_lane, instantiated CHANNELS times.
  - Contents: 8-bit shift register, optional brightness scaler, and the high-time compare.
  - Inputs: load, shift, tick.
- neopixel_multi_driver owns the FSM, tick/bit/byte counters and address.

Test Plan:
- 50 MHz, LEDS=2, CHANNELS=2, BYTES_PER_LED=3. Lane0 all bytes 0xFF, lane1 all bytes 0x00; pulse i_start. Required response:
  - Every bit of lane0 high for 35 cycles and lane1 high for 17, period 65.
  - 48 bits per lane, then 2500 low cycles.
  - o_frame_done pulses exactly once; o_busy falls with it.
- Byte 0xA5 on lane0 → high widths 35,17,35,17,17,35,17,35.
  - o_rd_addr steps 0→1 at tick 62 of bit 7.
  - No gap cycle between bytes.
- BYTES_PER_LED=4, LEDS=1 → 32 bits, o_rd_addr reaches 3 and never 4.
- i_start re-pulsed mid-frame and in the DONE cycle → ignored; frame length unchanged.
  - A start one cycle after DONE is accepted.
- i_rst asserted at bit 10 → next cycle o_neopixel_out=0, o_busy=0, o_rd_addr=0.
  - A following start produces a full, correct frame.
- NEOPIXEL_BRIGHTNESS_EN, data 0xFF, brightness 0x7F → byte 0x7F transmitted.
  - brightness changed mid-frame → no effect until the next frame.
